// File: rtl/ext_buffer_pkg.sv
// Shared types and width helpers for the multi-channel ext elastic buffer.
package ext_buffer_pkg;

    // Per-channel pointer state is held at a fixed width, and each FIFO uses the low bits it needs.
    localparam int unsigned STATE_PTR_W = 16;

    typedef struct packed {
        logic [STATE_PTR_W-1:0] wr_ptr;
        logic [STATE_PTR_W-1:0] rd_ptr;
        logic [STATE_PTR_W:0]   level;
    } ext_buffer_mc_state_t;

    typedef enum logic {
        ARB_OPEN = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int unsigned level_width(input int unsigned depth);
        return ptr_width(depth) + 1;
    endfunction

    function automatic int unsigned chan_width(input int unsigned nb);
        return (nb <= 1) ? 1 : $clog2(nb);
    endfunction

endpackage

// File: rtl/ext_buffer_mc_fifo.sv
// Single-channel FIFO slice of ext_buffer_mc: registered storage, level tracking, synchronous flush.
module ext_buffer_mc_fifo
    import ext_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BUFFER_DEPTH     = 4,
    parameter int unsigned LOG_BUFFER_DEPTH = ptr_width(BUFFER_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        pop_i,
    output logic [DATA_WIDTH-1:0]       head_o,
    output logic [LOG_BUFFER_DEPTH:0]   level_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam logic [STATE_PTR_W-1:0] LAST_PTR  = STATE_PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [STATE_PTR_W-1:0] ONE_PTR   = STATE_PTR_W'(1);
    localparam logic [STATE_PTR_W:0]   DEPTH_LVL = (STATE_PTR_W + 1)'(BUFFER_DEPTH);
    localparam logic [STATE_PTR_W:0]   ONE_LVL   = (STATE_PTR_W + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    ext_buffer_mc_state_t  state_q, state_d;
    logic                  do_push, do_pop;

    assign full_o  = (state_q.level == DEPTH_LVL);
    assign empty_o = (state_q.level == '0);
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    assign head_o  = mem_q[state_q.rd_ptr[LOG_BUFFER_DEPTH-1:0]];
    assign level_o = state_q.level[LOG_BUFFER_DEPTH:0];

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = '0;
        end else begin
            if (do_push) begin
                state_d.wr_ptr = (state_q.wr_ptr == LAST_PTR) ? '0 : state_q.wr_ptr + ONE_PTR;
            end
            if (do_pop) begin
                state_d.rd_ptr = (state_q.rd_ptr == LAST_PTR) ? '0 : state_q.rd_ptr + ONE_PTR;
            end
            case ({do_push, do_pop})
                2'b10:   state_d.level = state_q.level + ONE_LVL;
                2'b01:   state_d.level = state_q.level - ONE_LVL;
                default: state_d.level = state_q.level;
            endcase
        end
    end

    // Flush only rewinds the pointers; stale storage is never visible because level is 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= '0;
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (do_push) begin
                mem_q[state_q.wr_ptr[LOG_BUFFER_DEPTH-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/ext_buffer_mc.sv
// Multi-channel ext elastic buffer: per-channel FIFOs merged by a grant-holding round-robin arbiter.
// Optional zero-latency bypass of empty channels when EXT_BUFFER_MC_FALL_THROUGH_EN is defined.
module ext_buffer_mc
    import ext_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BUFFER_DEPTH     = 4,
    parameter int unsigned NB_CHANNELS      = 2,
    parameter int unsigned AF_THRESH        = BUFFER_DEPTH - 1,
    parameter int unsigned LOG_BUFFER_DEPTH = ptr_width(BUFFER_DEPTH),
    parameter int unsigned LOG_NB_CHANNELS  = chan_width(NB_CHANNELS)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        flush_i,
    input  logic [NB_CHANNELS-1:0]                      valid_i,
    input  logic [NB_CHANNELS-1:0][DATA_WIDTH-1:0]      data_i,
    output logic [NB_CHANNELS-1:0]                      ready_o,
    output logic [NB_CHANNELS-1:0][LOG_BUFFER_DEPTH:0]  level_o,
    output logic [NB_CHANNELS-1:0]                      almost_full_o,
    output logic                                        valid_o,
    output logic [DATA_WIDTH-1:0]                       data_o,
    output logic [LOG_NB_CHANNELS-1:0]                  chan_o,
    input  logic                                        ready_i
);

    // state    | meaning
    // ARB_OPEN | grant recomputed every cycle from rr_q
    // ARB_HOLD | output stalled; grant frozen on gnt_q until pop or flush

    localparam logic [LOG_NB_CHANNELS-1:0] LAST_CHAN = LOG_NB_CHANNELS'(NB_CHANNELS - 1);
    localparam logic [LOG_NB_CHANNELS-1:0] ONE_CHAN  = LOG_NB_CHANNELS'(1);
    localparam logic [LOG_BUFFER_DEPTH:0]  AF_LVL    = (LOG_BUFFER_DEPTH + 1)'(AF_THRESH);

    logic [NB_CHANNELS-1:0]                 full, empty, req;
    logic [NB_CHANNELS-1:0]                 fifo_push, fifo_pop, pop_sel;
    logic [NB_CHANNELS-1:0][DATA_WIDTH-1:0] head;

    arb_state_e                 arb_q, arb_d;
    logic [LOG_NB_CHANNELS-1:0] gnt_q, gnt_d, rr_q, rr_d;
    logic [LOG_NB_CHANNELS-1:0] grant;
    logic                       found, bypass, pop;
    int                         idx;

    assign ready_o = ~full & {NB_CHANNELS{~flush_i}};

`ifdef EXT_BUFFER_MC_FALL_THROUGH_EN
    assign req    = ~empty | (valid_i & {NB_CHANNELS{~flush_i}});
    assign bypass = empty[grant];
    assign data_o = bypass ? data_i[grant] : head[grant];
`else
    assign req    = ~empty;
    assign bypass = 1'b0;
    assign data_o = head[grant];
`endif

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (arb_q == ARB_HOLD) begin
            grant = gnt_q;
            found = 1'b1;
        end else begin
            for (int i = 0; i < NB_CHANNELS; i++) begin
                idx = int'(rr_q) + i;
                if (idx >= int'(NB_CHANNELS)) begin
                    idx = idx - int'(NB_CHANNELS);
                end
                if (!found && req[idx[LOG_NB_CHANNELS-1:0]]) begin
                    found = 1'b1;
                    grant = idx[LOG_NB_CHANNELS-1:0];
                end
            end
        end
    end

    assign valid_o = found;
    assign chan_o  = grant;
    assign pop     = valid_o & ready_i & ~flush_i;

    always_comb begin
        pop_sel        = '0;
        pop_sel[grant] = pop;
    end

    always_comb begin
        arb_d = arb_q;
        gnt_d = gnt_q;
        rr_d  = rr_q;
        if (flush_i) begin
            arb_d = ARB_OPEN;
            gnt_d = '0;
            rr_d  = '0;
        end else if (pop) begin
            arb_d = ARB_OPEN;
            rr_d  = (grant == LAST_CHAN) ? '0 : grant + ONE_CHAN;
        end else if (valid_o && !ready_i) begin
            arb_d = ARB_HOLD;
            gnt_d = grant;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arb_q <= ARB_OPEN;
            gnt_q <= '0;
            rr_q  <= '0;
        end else begin
            arb_q <= arb_d;
            gnt_q <= gnt_d;
            rr_q  <= rr_d;
        end
    end

    for (genvar c = 0; c < NB_CHANNELS; c++) begin : g_chan
        // A bypassed entry that is consumed immediately must not also be stored.
        assign fifo_push[c] = valid_i[c] & ready_o[c] & ~(pop_sel[c] & bypass);
        assign fifo_pop[c]  = pop_sel[c] & ~bypass;
        assign almost_full_o[c] = (level_o[c] >= AF_LVL);

        ext_buffer_mc_fifo #(
            .DATA_WIDTH       (DATA_WIDTH),
            .BUFFER_DEPTH     (BUFFER_DEPTH),
            .LOG_BUFFER_DEPTH (LOG_BUFFER_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .push_i  (fifo_push[c]),
            .data_i  (data_i[c]),
            .pop_i   (fifo_pop[c]),
            .head_o  (head[c]),
            .level_o (level_o[c]),
            .full_o  (full[c]),
            .empty_o (empty[c])
        );
    end

endmodule

// File: tb/tb_ext_buffer_mc.sv
// Directed bench for ext_buffer_mc (DEPTH=4, 2 channels, AF_THRESH=3); honours EXT_BUFFER_MC_FALL_THROUGH_EN.
module tb_ext_buffer_mc;

    localparam int DW = 32;
    localparam int NB = 2;
    localparam int LB = 2;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic                     flush_i;
    logic [NB-1:0]            valid_i;
    logic [NB-1:0][DW-1:0]    data_i;
    logic [NB-1:0]            ready_o;
    logic [NB-1:0][LB:0]      level_o;
    logic [NB-1:0]            almost_full_o;
    logic                     valid_o;
    logic [DW-1:0]            data_o;
    logic [0:0]               chan_o;
    logic                     ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ext_buffer_mc #(
        .DATA_WIDTH   (DW),
        .BUFFER_DEPTH (4),
        .NB_CHANNELS  (NB),
        .AF_THRESH    (3)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .data_i        (data_i),
        .ready_o       (ready_o),
        .level_o       (level_o),
        .almost_full_o (almost_full_o),
        .valid_o       (valid_o),
        .data_o        (data_o),
        .chan_o        (chan_o),
        .ready_i       (ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        valid_i = '0;
        data_i  = '0;
        ready_i = 1'b0;
        #2;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_chan", chan_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_af", almost_full_o, 0);
        chk("rst_ready", ready_o, 2'b11);
        #10 rst_ni = 1'b1;
        tick();

`ifndef EXT_BUFFER_MC_FALL_THROUGH_EN
        // ch0 push A1, A2 with downstream always ready
        valid_i = 2'b01; data_i[0] = 32'hA1; ready_i = 1'b1;
        settle();
        chk("a_valid_same_cycle", valid_o, 0);
        tick();
        data_i[0] = 32'hA2;
        settle();
        chk("a_valid", valid_o, 1);
        chk("a_data0", data_o, 32'hA1);
        chk("a_chan0", chan_o, 0);
        chk("a_level1", level_o[0], 1);
        tick();
        valid_i = '0;
        settle();
        chk("a_data1", data_o, 32'hA2);
        chk("a_level1b", level_o[0], 1);
        tick();
        settle();
        chk("a_empty_valid", valid_o, 0);
        chk("a_empty_level", level_o[0], 0);

        // fill ch1 to full while stalled
        ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            valid_i = 2'b10; data_i[1] = 32'h11 + k;
            tick();
            settle();
            chk("f_level", level_o[1], k + 1);
            chk("f_af", almost_full_o[1], (k + 1) >= 3);
            chk("f_ready", ready_o[1], (k + 1) < 4);
        end
        valid_i = 2'b10; data_i[1] = 32'h15; ready_i = 1'b1;
        settle();
        chk("f_full_ready_pop", ready_o[1], 0);
        chk("f_head", data_o, 32'h11);
        chk("f_chan", chan_o, 1);
        tick();
        valid_i = '0;
        settle();
        chk("f_level_after_reject", level_o[1], 3);
        chk("f_data12", data_o, 32'h12);
        tick(); settle();
        chk("f_data13", data_o, 32'h13);
        tick(); settle();
        chk("f_data14", data_o, 32'h14);
        tick(); settle();
        chk("f_drained_valid", valid_o, 0);
        chk("f_drained_level", level_o[1], 0);

        // both channels hold three entries, round-robin alternation
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid_i = 2'b11; data_i[0] = 32'h30 + k; data_i[1] = 32'h40 + k;
            tick();
        end
        valid_i = '0; ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("rr_chan", chan_o, k % 2);
            chk("rr_data", data_o, ((k % 2) != 0 ? 32'h40 : 32'h30) + (k / 2));
            tick();
        end
        settle();
        chk("rr_done_valid", valid_o, 0);

        // grant held on ch0 while ch1 fills behind it
        ready_i = 1'b0; valid_i = 2'b01; data_i[0] = 32'hB0;
        tick();
        for (int k = 0; k < 5; k++) begin
            valid_i = (k < 4) ? 2'b10 : 2'b00; data_i[1] = 32'h51 + k;
            settle();
            chk("s_data", data_o, 32'hB0);
            chk("s_chan", chan_o, 0);
            tick();
        end
        valid_i = '0; ready_i = 1'b1;
        settle();
        chk("s_first_pop_data", data_o, 32'hB0);
        chk("s_first_pop_chan", chan_o, 0);
        tick();
        ready_i = 1'b0;
        settle();
        chk("s_next_data", data_o, 32'h51);
        chk("s_next_chan", chan_o, 1);
        chk("s_ch1_level", level_o[1], 4);

        // flush collides with a push on ch0 and a pop on ch1
        flush_i = 1'b1; valid_i = 2'b01; data_i[0] = 32'hEE; ready_i = 1'b1;
        settle();
        chk("fl_ready_low", ready_o, 2'b00);
        tick();
        flush_i = 1'b0; valid_i = '0; ready_i = 1'b0;
        settle();
        chk("fl_level", level_o, 0);
        chk("fl_valid", valid_o, 0);
        chk("fl_ready", ready_o, 2'b11);
        valid_i = 2'b11; data_i[0] = 32'h61; data_i[1] = 32'h71;
        tick();
        valid_i = '0;
        settle();
        chk("fl_rr_chan", chan_o, 0);
        chk("fl_rr_data", data_o, 32'h61);
        ready_i = 1'b1;
        tick(); settle();
        chk("fl_ch1_chan", chan_o, 1);
        chk("fl_ch1_data", data_o, 32'h71);
        tick(); settle();
        chk("fl_end_valid", valid_o, 0);
        chk("fl_end_level", level_o, 0);
`else
        // zero-latency bypass, consumed immediately
        valid_i = 2'b10; data_i[1] = 32'hC3; ready_i = 1'b1;
        settle();
        chk("ft_valid", valid_o, 1);
        chk("ft_data", data_o, 32'hC3);
        chk("ft_chan", chan_o, 1);
        tick();
        valid_i = '0;
        settle();
        chk("ft_level", level_o[1], 0);
        chk("ft_valid_after", valid_o, 0);

        // bypass not consumed: stored and held
        valid_i = 2'b01; data_i[0] = 32'hD4; ready_i = 1'b0;
        settle();
        chk("ft_hold_valid", valid_o, 1);
        chk("ft_hold_data", data_o, 32'hD4);
        chk("ft_hold_chan", chan_o, 0);
        tick();
        valid_i = '0; data_i[0] = '0;
        settle();
        chk("ft_hold_data_next", data_o, 32'hD4);
        chk("ft_hold_chan_next", chan_o, 0);
        chk("ft_hold_level", level_o[0], 1);
        ready_i = 1'b1;
        tick(); settle();
        chk("ft_drain_valid", valid_o, 0);
        chk("ft_drain_level", level_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
